// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
package piso_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake plus serial output bundle; master is the word source, slave is the transmitter.
interface piso_tx_if
    import piso_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: one N-bit word per handshake, one bit per clock,
// gapless when the next word is offered on the last bit.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned N         = DEFAULT_N,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic       clk,
    input logic       reset_n,
    piso_tx_if.slave  bus
);
    localparam int unsigned CW = $clog2(N);

    state_t        state;
    logic [N-1:0]  sreg;
    logic [N-1:0]  sreg_shift;
    logic [CW-1:0] cnt;
    logic          out_q;
    logic          valid_q;
    logic          last_q;
    logic          busy_q;
    logic          xfer;

    // Bit at the output end of a word
    function automatic logic out_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    always_comb begin
        sreg_shift = MSB_FIRST ? {sreg[N-2:0], 1'b0} : {1'b0, sreg[N-1:1]};
    end

    // Ready is a decode of registered state only; last_q implies SHIFT at count N-1
    assign bus.in_ready = (state == IDLE) || last_q;
    assign xfer         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (xfer) begin
            state   <= SHIFT;
            sreg    <= bus.in_data;
            cnt     <= '0;
            out_q   <= out_bit(bus.in_data);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else if (state == SHIFT && !last_q) begin
            sreg    <= sreg_shift;
            cnt     <= cnt + CW'(1);
            out_q   <= out_bit(sreg_shift);
            last_q  <= (cnt == CW'(N - 2));
        end else if (last_q) begin
            // Final bit shown with no follow-on word: drop back to idle
            state   <= IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end
    end

    assign bus.ser_out   = out_q;
    assign bus.ser_valid = valid_q;
    assign bus.ser_last  = last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share one stimulus stream and
// are compared each cycle against a word/bit-position reference model.
module tb_piso_tx;
    localparam int unsigned N = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    piso_tx_if #(.N(N)) mif ();
    piso_tx_if #(.N(N)) lif ();

    piso_tx #(.N(N), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset_n(reset_n), .bus(mif.slave));
    piso_tx #(.N(N), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset_n(reset_n), .bus(lif.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: current word and index of the bit on the wire (-1 when idle)
    logic [N-1:0] mword = '0;
    int           pos   = -1;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (pos < 0) || (pos == int'(N) - 1);
    endfunction

    function automatic logic m_valid();
        return pos >= 0;
    endfunction

    function automatic logic m_last();
        return pos == int'(N) - 1;
    endfunction

    function automatic logic m_bit(input bit msb);
        if (pos < 0) return 1'b0;
        return msb ? mword[int'(N) - 1 - pos] : mword[pos];
    endfunction

    task automatic check_outputs();
        check("m_ser_valid", mif.ser_valid, m_valid());
        check("m_ser_last",  mif.ser_last,  m_last());
        check("m_ser_out",   mif.ser_out,   m_bit(1'b1));
        check("m_busy",      mif.busy,      m_valid());
        check("l_ser_valid", lif.ser_valid, m_valid());
        check("l_ser_last",  lif.ser_last,  m_last());
        check("l_ser_out",   lif.ser_out,   m_bit(1'b0));
        check("l_busy",      lif.busy,      m_valid());
    endtask

    task automatic drive(input logic v, input logic [N-1:0] d);
        mif.in_valid = v;
        mif.in_data  = d;
        lif.in_valid = v;
        lif.in_data  = d;
    endtask

    // One clock: drive at negedge, advance model at posedge, check at next negedge
    task automatic step(input logic v, input logic [N-1:0] d, output logic accepted);
        logic rdy;
        drive(v, d);
        #1;
        rdy = m_ready();
        check("m_in_ready", mif.in_ready, rdy);
        check("l_in_ready", lif.in_ready, rdy);
        @(posedge clk);
        accepted = v && rdy;
        if (accepted) begin
            mword = d;
            pos   = 0;
        end else if (pos >= 0) begin
            pos = (pos == int'(N) - 1) ? -1 : pos + 1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, N'($urandom), acc);
    endtask

    // Offer a word until taken; with scramble, data is noise until the model is ready
    task automatic push_word(input logic [N-1:0] data, input bit scramble);
        logic acc;
        logic [N-1:0] d;
        acc = 1'b0;
        for (int i = 0; i < 2 * int'(N) + 2 && !acc; i++) begin
            d = (scramble && !m_ready()) ? N'($urandom) : data;
            step(1'b1, d, acc);
        end
        check("accept_in_time", acc, 1'b1);
    endtask

    task automatic reset_pulse_check();
        #2 reset_n = 1'b0;
        #1;
        pos = -1;
        check_outputs();
        check("m_in_ready_rst", mif.in_ready, 1'b1);
        check("l_in_ready_rst", lif.in_ready, 1'b1);
        drive(1'b1, 8'h55);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        drive(1'b0, '0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic acc;
        drive(1'b0, '0);
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Single words: A5 on both orders, then 01
        push_word(8'hA5, 1'b0);
        idle_cycles(int'(N) + 1);
        push_word(8'h01, 1'b0);
        idle_cycles(int'(N) + 1);

        // Back-to-back FF then 00 with valid held
        push_word(8'hFF, 1'b0);
        push_word(8'h00, 1'b0);
        idle_cycles(int'(N) + 1);

        // Stall with changing data until acceptance; 3C is what sits on the bus at ser_last
        push_word(8'hC3, 1'b0);
        push_word(8'h3C, 1'b1);
        idle_cycles(int'(N) + 1);

        // Abort F0 after three bits, then send 81 cleanly
        push_word(8'hF0, 1'b0);
        idle_cycles(2);
        reset_pulse_check();
        push_word(8'h81, 1'b0);
        idle_cycles(int'(N) + 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), N'($urandom), acc);
            if (i == 200) reset_pulse_check();
        end
        idle_cycles(int'(N) + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter: the sending end for the team's serial shift-register links. It accepts N-bit words on a valid/ready handshake and shifts each word out one bit per clock, with a bit-valid strobe and a last-bit marker. Back-to-back words stream with no idle gap. It feeds serial receivers such as the shift-register chains elsewhere in the design.

## Interface
- N, 8: word width in bits; legal range N >= 2.
- MSB_FIRST, 1: 1 sends bit N-1 first; 0 sends bit 0 first.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  N  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- ser_out  output  1  serial data bit; 0 whenever ser_valid = 0.
- ser_valid  output  1  ser_out carries a valid bit this cycle.
- ser_last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is being shifted (equals ser_valid).

## Operation
- Reset (reset_n low) takes effect immediately, without waiting for clk:
  - state = IDLE; shift register = 0; bit counter = 0.
  - ser_out = 0, ser_valid = 0, ser_last = 0, busy = 0.
- While reset_n is low, no transfer occurs.
- States:
  - IDLE: ser_valid = 0. in_ready = 1.
  - SHIFT: ser_valid = 1. The counter tracks the bit index, 0 .. N-1.
- Transfer: in_valid && in_ready at a rising edge.
  - The word is loaded into the shift register.
  - Counter is set to 0; state goes to SHIFT.
- In SHIFT, each edge with counter < N-1:
  - The shift register moves one position toward the output end: left if MSB_FIRST, right otherwise.
  - Counter increments.
- ser_out is taken from the output end of the shift register: bit N-1 if MSB_FIRST, bit 0 otherwise.
- ser_last = 1 exactly when state = SHIFT and counter = N-1.
- in_ready = (state == IDLE) || ser_last. This is combinational from registered state, with no combinational path from in_valid.
- At an edge with ser_last = 1:
  - If a transfer occurs, the new word loads, the counter resets to 0, and the state stays SHIFT. The result is gapless streaming.
  - If no transfer occurs, the state returns to IDLE.
- Word bits are sampled only at the transfer edge. Later changes to in_data have no effect.
- in_valid held high while in_ready = 0 is simply stalled. No error, no loss.
- Counter width is $clog2(N). Its wrap-around is never reached, because the counter is reloaded on the last bit.

## Timing
- Latency: the first bit is on ser_out in the cycle immediately after the transfer edge, driven from registers.
- Duration: a word occupies exactly N consecutive ser_valid cycles.
- Throughput: one word per N cycles when in_valid is held high.
- Inter-word gap: 0 cycles on a back-to-back load; otherwise at least 1 IDLE cycle.
- Reset mid-word: outputs clear asynchronously. The partial word is discarded, not resumed. The first transfer after deassertion starts a fresh word.
- Only ser_out, ser_valid, ser_last and busy are registered outputs. in_ready is registered-state decode.

## Structure
- Shared package piso_pkg:
  - state typedef: IDLE, SHIFT.
  - Default width constant.
- No sub-module; one FSM + shift register + counter process.
- Optional reusable helper: bit_counter (load / increment / terminal count) if the team wants it shared with receivers.

## Test plan
- Reset state: assert reset_n = 0 mid-simulation, off a clock edge -> all outputs 0 immediately; in_ready = 1 after release.
- Single word, N=8, MSB_FIRST=1, in_data = 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles, starting the cycle after the transfer. ser_last only on the 8th bit. Then IDLE.
- LSB_FIRST (MSB_FIRST=0), in_data = 8'h01 -> ser_out 1 then seven 0s.
- Back-to-back: 8'hFF then 8'h00 with in_valid held -> 16 contiguous ser_valid cycles (eight 1s, eight 0s). in_ready high only on ser_last and the initial IDLE cycle.
- Stall: in_valid asserted with in_data = 8'h3C while shifting a prior word, in_data changed each cycle until accepted -> only the value present at the ser_last edge is transmitted. No word is lost or duplicated.
- Reset mid-word: reset_n low after 3 bits of 8'hF0, then a new word 8'h81 -> output bits 1,0,0,0,0,0,0,1 with no residue of the aborted word.
